adc_capture_ctrl: RTL and testbench

Triggered capture controller sitting between the RFSoC ADC AXI-Stream output and `axis_pl_to_ps`. It watches the continuous 128-bit ADC stream (8 signed 16-bit samples per beat) and, once armed by software, captures a programmed number of beats. Capture starts either immediately or on a sample-magnitude threshold. Captured beats are buffered in an on-chip FIFO and presented as a 128-bit AXI-Stream to the PL-to-PS clock-crossing stage. Everything runs in the `pl_clk` domain.

---
 rtl/adc_capture_ctrl_pkg.sv | 34 +++
 rtl/adc_capture_ctrl_fifo.sv | 55 +++++
 rtl/adc_capture_ctrl.sv | 128 ++++++++++++
 tb/tb_adc_capture_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_capture_ctrl_pkg.sv
// Shared definitions for the RFSoC ADC capture path: gpio_ctrl bit map,
// capture FSM states, status layout and the per-sample magnitude helper.
package rfsoc_config;

   localparam int unsigned adc_buffer_flush = 0;
   localparam int unsigned adc_capture_arm  = 1;
   localparam int unsigned adc_trig_mode    = 2;

   localparam int unsigned ADC_LANES  = 8;
   localparam int unsigned ADC_SAMP_W = 16;
   localparam int unsigned ADC_BEAT_W = ADC_LANES * ADC_SAMP_W;

   typedef enum logic [1:0] {
      CAP_IDLE    = 2'd0,
      CAP_ARMED   = 2'd1,
      CAP_CAPTURE = 2'd2,
      CAP_DONE    = 2'd3
   } adc_cap_state_t;

   typedef struct packed {
      logic overflow;
      logic triggered;
      logic done;
      logic busy;
   } adc_cap_status_t;

   // 17-bit result so that -32768 maps to +32768 instead of wrapping.
   function automatic logic [ADC_SAMP_W:0] samp_abs(input logic [ADC_SAMP_W-1:0] s);
      logic [ADC_SAMP_W:0] x;
      x = {s[ADC_SAMP_W-1], s};
      return s[ADC_SAMP_W-1] ? ((ADC_SAMP_W+1)'(0) - x) : x;
   endfunction

endpackage

// File: rtl/adc_capture_ctrl_fifo.sv
// First-word-fall-through synchronous FIFO; the head word is visible on rd_data_o
// while not empty. Pointers carry an extra wrap bit to tell full from empty.
module sync_fifo_fwft #(
   parameter int WIDTH = 128,
   parameter int DEPTH = 512
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clear_i,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             rd_en_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wptr_q, rptr_q;
   logic [AW:0]      wptr_d, rptr_d;
   logic             do_wr, do_rd;

   assign empty_o = (wptr_q == rptr_q);
   assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

   // Full is the pre-pop view, so a same-cycle pop never makes room for a write.
   assign do_wr = wr_en_i && !full_o;
   assign do_rd = rd_en_i && !empty_o;

   assign rd_data_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (do_wr) wptr_d = wptr_q + (AW+1)'(1);
      if (do_rd) rptr_d = rptr_q + (AW+1)'(1);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni || clear_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_wr) mem_q[wptr_q[AW-1:0]] <= wr_data_i;
   end

endmodule

// File: rtl/adc_capture_ctrl.sv
// Triggered capture of the 128-bit ADC stream into a FWFT FIFO feeding the
// PL-to-PS stage: arm on a gpio edge, start immediately or on a magnitude hit.
module adc_capture_ctrl
   import rfsoc_config::*;
#(
   parameter int DEPTH = 512
) (
   input  logic                  pl_clk,
   input  logic                  rst,
   input  logic [ADC_BEAT_W-1:0] s_adc_tdata,
   input  logic                  s_adc_tvalid,
   output logic [ADC_BEAT_W-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   input  logic [15:0]           gpio_ctrl,
   input  logic [15:0]           capture_len,
   input  logic [15:0]           trig_threshold,
   output logic [3:0]            status
);

   adc_cap_state_t  state_q;
   adc_cap_status_t stat_q;
   logic [15:0]     count_q, len_q, thr_q;
   logic [15:0]     count_inc;
   logic            arm_q;

   logic                 flush, arm_edge, trig_mode, hit, fifo_wr;
   logic                 fifo_full, fifo_empty;
   logic [ADC_LANES-1:0] lane_hit;
   logic                 unused_gpio;

   assign flush       = gpio_ctrl[adc_buffer_flush];
   assign trig_mode   = gpio_ctrl[adc_trig_mode];
   assign arm_edge    = gpio_ctrl[adc_capture_arm] && !arm_q;
   assign unused_gpio = ^gpio_ctrl;
   assign count_inc   = count_q + 16'd1;

   for (genvar k = 0; k < ADC_LANES; k++) begin : g_lane
      assign lane_hit[k] = samp_abs(s_adc_tdata[ADC_SAMP_W*k +: ADC_SAMP_W]) >= {1'b0, thr_q};
   end
   assign hit = |lane_hit;

   // The triggering beat itself is the first captured word.
   assign fifo_wr = !flush && s_adc_tvalid &&
                    ((state_q == CAP_CAPTURE) || ((state_q == CAP_ARMED) && hit));

   sync_fifo_fwft #(
      .WIDTH (ADC_BEAT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i     (pl_clk),
      .rst_ni    (rst),
      .clear_i   (flush),
      .wr_en_i   (fifo_wr),
      .wr_data_i (s_adc_tdata),
      .rd_en_i   (m_axis_tready),
      .rd_data_o (m_axis_tdata),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty)
   );

   assign m_axis_tvalid = !fifo_empty;
   assign status        = stat_q;

   always_ff @(posedge pl_clk) begin
      if (!rst) begin
         state_q <= CAP_IDLE;
         stat_q  <= '0;
         count_q <= '0;
         len_q   <= '0;
         thr_q   <= '0;
         arm_q   <= 1'b0;
      end else begin
         // Track the arm bit even during flush so a held bit is not re-seen later.
         arm_q <= gpio_ctrl[adc_capture_arm];
         if (flush) begin
            state_q <= CAP_IDLE;
            stat_q  <= '0;
            count_q <= '0;
         end else begin
            case (state_q)
               CAP_IDLE, CAP_DONE: begin
                  if (arm_edge) begin
                     len_q   <= capture_len;
                     thr_q   <= trig_threshold;
                     count_q <= '0;
                     stat_q  <= '{overflow:  1'b0,
                                  triggered: 1'b0,
                                  done:      (capture_len == 16'd0),
                                  busy:      (capture_len != 16'd0)};
                     if (capture_len == 16'd0) state_q <= CAP_DONE;
                     else if (trig_mode)       state_q <= CAP_ARMED;
                     else                      state_q <= CAP_CAPTURE;
                  end
               end
               CAP_ARMED: begin
                  if (s_adc_tvalid && hit) begin
                     count_q          <= 16'd1;
                     stat_q.triggered <= 1'b1;
                     if (fifo_full) stat_q.overflow <= 1'b1;
                     if (len_q == 16'd1) begin
                        state_q     <= CAP_DONE;
                        stat_q.done <= 1'b1;
                        stat_q.busy <= 1'b0;
                     end else begin
                        state_q <= CAP_CAPTURE;
                     end
                  end
               end
               CAP_CAPTURE: begin
                  // Window is fixed in ADC time: dropped beats still advance the count.
                  if (s_adc_tvalid) begin
                     count_q <= count_inc;
                     if (fifo_full) stat_q.overflow <= 1'b1;
                     if (count_inc == len_q) begin
                        state_q     <= CAP_DONE;
                        stat_q.done <= 1'b1;
                        stat_q.busy <= 1'b0;
                     end
                  end
               end
               default: state_q <= CAP_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed bench for adc_capture_ctrl: a trigger-comparator vector table plus
// hand-written sequences for capture, overflow, backpressure, flush and arm corners.
module tb_adc_capture_ctrl;
   import rfsoc_config::*;

   localparam int DEPTH = 4;

   logic         pl_clk = 1'b0;
   logic         rst = 1'b0;
   logic [127:0] s_adc_tdata = '0;
   logic         s_adc_tvalid = 1'b0;
   logic [127:0] m_axis_tdata;
   logic         m_axis_tvalid;
   logic         m_axis_tready = 1'b0;
   logic [15:0]  gpio_ctrl = '0;
   logic [15:0]  capture_len = '0;
   logic [15:0]  trig_threshold = '0;
   logic [3:0]   status;

   adc_capture_ctrl #(.DEPTH(DEPTH)) dut (
      .pl_clk         (pl_clk),
      .rst            (rst),
      .s_adc_tdata    (s_adc_tdata),
      .s_adc_tvalid   (s_adc_tvalid),
      .m_axis_tdata   (m_axis_tdata),
      .m_axis_tvalid  (m_axis_tvalid),
      .m_axis_tready  (m_axis_tready),
      .gpio_ctrl      (gpio_ctrl),
      .capture_len    (capture_len),
      .trig_threshold (trig_threshold),
      .status         (status)
   );

   always #5 pl_clk = ~pl_clk;

   int           n_tests = 0;
   int           n_fail  = 0;
   logic [127:0] rx_q[$];

   typedef struct {
      int          lane;
      logic [15:0] samp;
      logic [15:0] thr;
      logic        hit;
   } trig_vec_t;

   trig_vec_t vecs[9];

   function automatic logic [127:0] beat(input int n);
      logic [127:0] b;
      for (int k = 0; k < 8; k++) b[16*k +: 16] = 16'(n*8 + k);
      return b;
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Records any handshake of the coming edge, then advances to just after it.
   task automatic step();
      #1;
      if (m_axis_tvalid && m_axis_tready) rx_q.push_back(m_axis_tdata);
      @(posedge pl_clk);
      #1;
   endtask

   task automatic idle(input int n);
      s_adc_tvalid = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic send(input logic [127:0] d);
      s_adc_tdata  = d;
      s_adc_tvalid = 1'b1;
      step();
      s_adc_tvalid = 1'b0;
   endtask

   task automatic do_flush();
      s_adc_tvalid = 1'b0;
      gpio_ctrl[adc_buffer_flush] = 1'b1;
      step();
      gpio_ctrl[adc_buffer_flush] = 1'b0;
      rx_q.delete();
   endtask

   task automatic arm(input logic mode, input logic [15:0] len, input logic [15:0] thr);
      capture_len    = len;
      trig_threshold = thr;
      gpio_ctrl[adc_trig_mode]   = mode;
      gpio_ctrl[adc_capture_arm] = 1'b1;
      s_adc_tvalid = 1'b0;
      step();
      gpio_ctrl[adc_capture_arm] = 1'b0;
   endtask

   task automatic check_rx(input string name, input int first, input int n);
      check({name, " count"}, 128'(rx_q.size()), 128'(n));
      for (int i = 0; i < n && i < rx_q.size(); i++) check({name, " word"}, rx_q[i], beat(first + i));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [127:0] b;
      logic [127:0] prev_data;
      logic         prev_stall;
      int           sent;

      vecs[0] = '{lane: 5, samp: 16'hFC18, thr: 16'd1000,  hit: 1'b1};
      vecs[1] = '{lane: 5, samp: 16'hFC19, thr: 16'd1000,  hit: 1'b0};
      vecs[2] = '{lane: 0, samp: 16'h8000, thr: 16'd32767, hit: 1'b1};
      vecs[3] = '{lane: 7, samp: 16'h7FFF, thr: 16'd32767, hit: 1'b1};
      vecs[4] = '{lane: 3, samp: 16'h7FFF, thr: 16'hFFFF,  hit: 1'b0};
      vecs[5] = '{lane: 0, samp: 16'h8000, thr: 16'd32768, hit: 1'b1};
      vecs[6] = '{lane: 2, samp: 16'h0000, thr: 16'd0,     hit: 1'b1};
      vecs[7] = '{lane: 1, samp: 16'h03E7, thr: 16'd1000,  hit: 1'b0};
      vecs[8] = '{lane: 6, samp: 16'h8001, thr: 16'd32768, hit: 1'b0};

      // Reset state
      idle(3);
      check("reset tvalid", 128'(m_axis_tvalid), 128'(0));
      check("reset tdata", m_axis_tdata, 128'(0));
      check("reset status", 128'(status), 128'(0));
      rst = 1'b1;
      step();

      // Immediate capture: beat present at the arm edge is not captured
      m_axis_tready = 1'b1;
      capture_len = 16'd4;
      gpio_ctrl[adc_trig_mode]   = 1'b0;
      gpio_ctrl[adc_capture_arm] = 1'b1;
      send(beat(50));
      gpio_ctrl[adc_capture_arm] = 1'b0;
      send(beat(51));
      check("imm latency tvalid", 128'(m_axis_tvalid), 128'(1));
      check("imm latency tdata", m_axis_tdata, beat(51));
      check("imm busy", 128'(status), 128'(4'b0001));
      for (int i = 52; i <= 56; i++) send(beat(i));
      idle(3);
      check_rx("imm", 51, 4);
      check("imm status", 128'(status), 128'(4'b0010));

      // Threshold trigger on lane 5 = -1000 at beat 7
      do_flush();
      arm(1'b1, 16'd3, 16'd1000);
      for (int i = 0; i < 7; i++) send(beat(i));
      check("thr armed status", 128'(status), 128'(4'b0001));
      check("thr armed tvalid", 128'(m_axis_tvalid), 128'(0));
      b = beat(7);
      b[16*5 +: 16] = 16'hFC18;
      send(b);
      check("thr hit tdata", m_axis_tdata, b);
      check("thr hit status", 128'(status), 128'(4'b0101));
      send(beat(8));
      send(beat(9));
      idle(3);
      check("thr done status", 128'(status), 128'(4'b0110));
      check("thr rx count", 128'(rx_q.size()), 128'(3));
      if (rx_q.size() == 3) begin
         check("thr rx0", rx_q[0], b);
         check("thr rx1", rx_q[1], beat(8));
         check("thr rx2", rx_q[2], beat(9));
      end

      // Comparator table, one beat per vector with length 1
      m_axis_tready = 1'b0;
      foreach (vecs[v]) begin
         do_flush();
         arm(1'b1, 16'd1, vecs[v].thr);
         b = '0;
         b[16*vecs[v].lane +: 16] = vecs[v].samp;
         send(b);
         check($sformatf("tbl%0d status", v), 128'(status),
               vecs[v].hit ? 128'(4'b0110) : 128'(4'b0001));
         check($sformatf("tbl%0d tvalid", v), 128'(m_axis_tvalid), 128'(vecs[v].hit));
      end

      // Overflow: DEPTH=4, length 10, no drain
      do_flush();
      arm(1'b0, 16'd10, 16'd0);
      for (int i = 0; i < 9; i++) send(beat(i));
      check("ovf 9 beats status", 128'(status), 128'(4'b1001));
      send(beat(9));
      check("ovf done status", 128'(status), 128'(4'b1010));
      check("ovf head", m_axis_tdata, beat(0));
      send(beat(10));
      check("ovf hold status", 128'(status), 128'(4'b1010));
      m_axis_tready = 1'b1;
      idle(6);
      check_rx("ovf", 0, 4);
      check("ovf drained", 128'(m_axis_tvalid), 128'(0));

      // Backpressure: sparse beats, random tready, never slower than 1 in 2
      do_flush();
      arm(1'b0, 16'd12, 16'd0);
      sent = 0;
      prev_stall = 1'b0;
      prev_data = '0;
      for (int i = 0; i < 120; i++) begin
         s_adc_tvalid = (i % 4 == 0) && (sent < 12);
         if (s_adc_tvalid) begin
            s_adc_tdata = beat(100 + sent);
            sent++;
         end
         m_axis_tready = (i % 2 == 1) ? 1'b1 : 1'($urandom_range(0, 1));
         if (prev_stall) begin
            check("bp stall tvalid", 128'(m_axis_tvalid), 128'(1));
            check("bp stall tdata", m_axis_tdata, prev_data);
         end
         prev_stall = m_axis_tvalid && !m_axis_tready;
         prev_data  = m_axis_tdata;
         step();
      end
      s_adc_tvalid = 1'b0;
      m_axis_tready = 1'b1;
      idle(3);
      check_rx("bp", 100, 12);
      check("bp status", 128'(status), 128'(4'b0010));

      // Arm edge during CAPTURE is ignored
      do_flush();
      arm(1'b0, 16'd5, 16'd0);
      send(beat(200));
      send(beat(201));
      gpio_ctrl[adc_capture_arm] = 1'b1;
      send(beat(202));
      gpio_ctrl[adc_capture_arm] = 1'b0;
      send(beat(203));
      check("rearm busy", 128'(status), 128'(4'b0001));
      send(beat(204));
      check("rearm done", 128'(status), 128'(4'b0010));
      send(beat(205));
      idle(2);
      check_rx("rearm", 200, 5);

      // Flush with 3 words buffered, coincident with a pop
      do_flush();
      m_axis_tready = 1'b0;
      arm(1'b0, 16'd10, 16'd0);
      for (int i = 300; i < 303; i++) send(beat(i));
      check("flush pre tvalid", 128'(m_axis_tvalid), 128'(1));
      m_axis_tready = 1'b1;
      gpio_ctrl[adc_buffer_flush] = 1'b1;
      step();
      gpio_ctrl[adc_buffer_flush] = 1'b0;
      check("flush tvalid", 128'(m_axis_tvalid), 128'(0));
      check("flush status", 128'(status), 128'(0));
      rx_q.delete();
      arm(1'b0, 16'd2, 16'd0);
      send(beat(310));
      send(beat(311));
      idle(2);
      check_rx("post flush", 310, 2);
      check("post flush status", 128'(status), 128'(4'b0010));

      // Zero length: immediate DONE, nothing captured
      do_flush();
      arm(1'b0, 16'd0, 16'd0);
      check("len0 status", 128'(status), 128'(4'b0010));
      for (int i = 400; i < 403; i++) send(beat(i));
      check("len0 tvalid", 128'(m_axis_tvalid), 128'(0));
      check("len0 hold status", 128'(status), 128'(4'b0010));

      // Reset mid-capture (armed from DONE); arm register is cleared by reset
      m_axis_tready = 1'b0;
      arm(1'b0, 16'd5, 16'd0);
      send(beat(500));
      send(beat(501));
      check("rst pre status", 128'(status), 128'(4'b0001));
      rst = 1'b0;
      capture_len = 16'd1;
      gpio_ctrl[adc_capture_arm] = 1'b1;
      step();
      rst = 1'b1;
      check("rst tvalid", 128'(m_axis_tvalid), 128'(0));
      check("rst status", 128'(status), 128'(0));
      step();
      check("rst held arm re-armed", 128'(status), 128'(4'b0001));
      gpio_ctrl[adc_capture_arm] = 1'b0;
      idle(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
